// File: rtl/rx_capture_ctrl.sv
// rx_capture_ctrl
// Writes one window of received video into the capture BRAM. An ARM request
// waits for the next frame start (rising O_VS), then every qualifying visible
// pixel is written as one byte at consecutive addresses from 0. Completion is
// reported on DONE. TRUNC is set if a frame edge ended the capture early.
//
// Ports
//   O_CLK       in   pixel clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   ENABLE      in   block enable; low aborts any capture
//   ARM         in   one-cycle capture request (ignored while BUSY)
//   WIN_Y       in   first captured line, latched when ARM is accepted
//   O_VS        in   vertical sync, rising edge = frame start
//   O_VISIBLE   in   current pixel is visible
//   O_X, O_Y    in   current pixel column / row
//   VIDEO       in   pixel sample, VIDEO[9:2] is stored
//   BRAM_ADDR   out  write address
//   BRAM_DIN    out  write data
//   BRAM_WE     out  write strobe
//   BUSY        out  waiting for a frame or capturing
//   DONE        out  capture finished, held until the next accepted ARM
//   TRUNC       out  last capture was cut short by a frame edge
//
// state        | meaning
// S_IDLE       | no capture requested
// S_WAIT_FRAME | armed, waiting for the next rising O_VS
// S_CAPTURE    | writing qualifying pixels
// S_DONE       | capture complete (DONE=1), waiting for a new ARM
module rx_capture_ctrl #(
  parameter int LINE_WIDTH = 576,
  parameter int NUM_LINES  = 28,
  parameter int ADDR_W     = 14,
  parameter int DEPTH      = 16384
) (
  input  logic              O_CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              ARM,
  input  logic [8:0]        WIN_Y,
  input  logic              O_VS,
  input  logic              O_VISIBLE,
  input  logic [9:0]        O_X,
  input  logic [8:0]        O_Y,
  input  logic [9:0]        VIDEO,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [7:0]        BRAM_DIN,
  output logic              BRAM_WE,
  output logic              BUSY,
  output logic              DONE,
  output logic              TRUNC
);

  localparam int CAP_LEN  = LINE_WIDTH * NUM_LINES;
  // The capture ends at whichever comes first: the full window or the BRAM end.
  localparam int LAST_IDX = (CAP_LEN < DEPTH) ? CAP_LEN - 1 : DEPTH - 1;
  localparam int CNT_W    = ADDR_W + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);
  localparam logic [9:0]       LW       = 10'(LINE_WIDTH);
  localparam logic [9:0]       NL       = 10'(NUM_LINES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              vs_q;
  logic [8:0]        win_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;
  logic              trunc_q;

  logic              vs_rise;
  logic [9:0]        win_end;
  logic              in_window;
  logic              qual;
  logic              last_write;
  logic [CNT_W-1:0]  wr_cnt_d;
  logic              unused_video_lsbs;

  assign vs_rise    = O_VS & ~vs_q;
  // 10-bit window end so a window starting near line 511 cannot wrap.
  assign win_end    = {1'b0, win_q} + NL;
  assign in_window  = (O_Y >= win_q) && ({1'b0, O_Y} < win_end);
  assign qual       = O_VISIBLE && (O_X < LW) && in_window;
  assign last_write = (wr_cnt_q == LAST_CNT);
  assign wr_cnt_d   = wr_cnt_q + CNT_W'(1);

  assign unused_video_lsbs = ^VIDEO[1:0];

  always_ff @(posedge O_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      vs_q     <= 1'b0;
      win_q    <= '0;
      wr_cnt_q <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      vs_q <= O_VS;
      we_q <= 1'b0;
      if (!ENABLE) begin
        // Abort: pipeline flushed, DONE/TRUNC left as they were.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (ARM) begin
              state_q  <= S_WAIT_FRAME;
              win_q    <= WIN_Y;
              wr_cnt_q <= '0;
              done_q   <= 1'b0;
              trunc_q  <= 1'b0;
              busy_q   <= 1'b1;
            end
          end
          S_WAIT_FRAME: begin
            // vs_q was refreshed on the accepting edge, so a frame edge
            // coincident with ARM is never seen here.
            if (vs_rise) begin
              state_q <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (vs_rise) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              trunc_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (qual) begin
              we_q     <= 1'b1;
              addr_q   <= wr_cnt_q[ADDR_W-1:0];
              din_q    <= VIDEO[9:2];
              wr_cnt_q <= wr_cnt_d;
              // The final byte is still presented on the cycle DONE rises.
              if (last_write) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign BRAM_ADDR = addr_q;
  assign BRAM_DIN  = din_q;
  assign BRAM_WE   = we_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign TRUNC     = trunc_q;

endmodule

// File: tb/tb_rx_capture_ctrl.sv
module tb_rx_capture_ctrl;

  localparam int LW    = 576;
  localparam int NL    = 28;
  localparam int LIMIT = 16128;

  logic        O_CLK;
  logic        RESET_N;
  logic        ENABLE;
  logic        ARM;
  logic [8:0]  WIN_Y;
  logic        O_VS;
  logic        O_VISIBLE;
  logic [9:0]  O_X;
  logic [8:0]  O_Y;
  logic [9:0]  VIDEO;
  logic [13:0] BRAM_ADDR;
  logic [7:0]  BRAM_DIN;
  logic        BRAM_WE;
  logic        BUSY;
  logic        DONE;
  logic        TRUNC;

  rx_capture_ctrl dut (
    .O_CLK     (O_CLK),
    .RESET_N   (RESET_N),
    .ENABLE    (ENABLE),
    .ARM       (ARM),
    .WIN_Y     (WIN_Y),
    .O_VS      (O_VS),
    .O_VISIBLE (O_VISIBLE),
    .O_X       (O_X),
    .O_Y       (O_Y),
    .VIDEO     (VIDEO),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_DIN  (BRAM_DIN),
    .BRAM_WE   (BRAM_WE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .TRUNC     (TRUNC)
  );

  initial O_CLK = 1'b0;
  always #5 O_CLK = ~O_CLK;

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int n_checks = 0;
  int n_err    = 0;
  int n_writes = 0;

  // Reference model: capture status in terms of frames and byte counts.
  bit m_wait  = 0;
  bit m_cap   = 0;
  bit m_done  = 0;
  bit m_trunc = 0;
  int m_win   = 0;
  int m_cnt   = 0;

  bit arm_pend = 0;
  int win_pend = 0;
  int drop_at  = -1;
  bit drop_now = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel clock of stimulus; expected writes are queued here.
  task automatic cyc(input logic vs, input logic vis, input int x, input int y);
    wr_t e;
    @(posedge O_CLK);
    #1;
    if (drop_now) begin
      ENABLE   = 1'b0;
      drop_now = 0;
      m_cap    = 0;
      m_wait   = 0;
    end
    O_VS      = vs;
    O_VISIBLE = vis;
    O_X       = 10'(x);
    O_Y       = 9'(y);
    VIDEO     = 10'($urandom);
    if (arm_pend) begin
      ARM      = 1'b1;
      WIN_Y    = 9'(win_pend);
      arm_pend = 0;
      if (ENABLE && !m_wait && !m_cap) begin
        m_wait  = 1;
        m_win   = win_pend;
        m_cnt   = 0;
        m_done  = 0;
        m_trunc = 0;
      end
    end else begin
      ARM = 1'b0;
    end
    if (m_cap && ENABLE && vis && x < LW && y >= m_win && y < m_win + NL) begin
      e.a = 14'(m_cnt);
      e.d = VIDEO[9:2];
      exp_q.push_back(e);
      m_cnt++;
      if (m_cnt == LIMIT) begin
        m_cap  = 0;
        m_done = 1;
      end
      if (m_cnt == drop_at) drop_now = 1;
    end
  endtask

  task automatic vs_start();
    bit was_wait;
    bit was_cap;
    was_wait = m_wait;
    was_cap  = m_cap;
    cyc(1'b1, 1'b0, 700, 0);
    if (was_cap) begin
      m_cap   = 0;
      m_done  = 1;
      m_trunc = 1;
    end
    if (was_wait) begin
      m_wait = 0;
      m_cap  = 1;
    end
    cyc(1'b1, 1'b0, 700, 0);
    cyc(1'b1, 1'b0, 700, 0);
    cyc(1'b0, 1'b0, 700, 0);
    cyc(1'b0, 1'b0, 700, 0);
  endtask

  // Lines flo..fhi sweep x=0..639 with random blanking gaps; other lines
  // carry a few random visible pixels only.
  task automatic run_frame(input int h, input int flo, input int fhi,
                           input int arm_line, input int arm_win);
    vs_start();
    for (int y = 0; y < h; y++) begin
      if (y == arm_line) begin
        arm_pend = 1;
        win_pend = arm_win;
      end
      if (y >= flo && y <= fhi) begin
        for (int x = 0; x < 640; x++) begin
          cyc(1'b0, 1'b1, x, y);
          if ($urandom_range(0, 63) == 0) cyc(1'b0, 1'b0, $urandom_range(0, 1023), y);
        end
      end else begin
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, $urandom_range(0, 639), y);
      end
      cyc(1'b0, 1'b0, 640, y);
      cyc(1'b0, 1'b0, 641, y);
    end
  endtask

  task automatic do_arm(input int w);
    arm_pend = 1;
    win_pend = w;
    repeat (3) cyc(1'b0, 1'b0, 700, 0);
  endtask

  task automatic chk_status(input string tag);
    @(negedge O_CLK);
    chk({tag, "_busy"},  int'(BUSY),  int'(m_wait || m_cap));
    chk({tag, "_done"},  int'(DONE),  int'(m_done));
    chk({tag, "_trunc"}, int'(TRUNC), int'(m_trunc));
  endtask

  always @(negedge O_CLK) begin
    if (RESET_N === 1'b1 && BRAM_WE === 1'b1) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0d din %0h, expected no write",
                 BRAM_ADDR, BRAM_DIN);
      end else begin
        mon_e = exp_q.pop_front();
        if (BRAM_ADDR !== mon_e.a || BRAM_DIN !== mon_e.d) begin
          n_err++;
          $display("FAIL write_data: got addr %0d din %0h, expected addr %0d din %0h",
                   BRAM_ADDR, BRAM_DIN, mon_e.a, mon_e.d);
        end
      end
    end
  end

  int w0;

  initial begin
    RESET_N   = 1'b0;
    ENABLE    = 1'b1;
    ARM       = 1'b0;
    WIN_Y     = '0;
    O_VS      = 1'b0;
    O_VISIBLE = 1'b0;
    O_X       = '0;
    O_Y       = '0;
    VIDEO     = '0;
    #2;
    chk("reset_addr", int'(BRAM_ADDR), 0);
    chk("reset_din", int'(BRAM_DIN), 0);
    chk("reset_we_busy_done_trunc", int'({BRAM_WE, BUSY, DONE, TRUNC}), 0);
    #20;
    @(negedge O_CLK);
    RESET_N = 1'b1;

    // Phase 1: no ARM for two frames.
    w0 = n_writes;
    run_frame(40, 5, 6, -1, 0);
    run_frame(40, 5, 6, -1, 0);
    chk_status("noarm");
    chk("noarm_writes", n_writes - w0, 0);

    // Phase 2: full window from line 10; a stray ARM mid-capture is ignored.
    do_arm(10);
    chk_status("armed");
    w0 = n_writes;
    run_frame(48, 9, 38, 20, 0);
    vs_start();
    chk_status("full");
    chk("full_done_const", int'(DONE), 1);
    chk("full_trunc_const", int'(TRUNC), 0);
    chk("full_writes", n_writes - w0, 16128);
    chk("full_queue_empty", exp_q.size(), 0);

    // Phase 3: ARM coincident with a frame edge waits for the following frame;
    // window at 470 of a 480-line frame is truncated.
    arm_pend = 1;
    win_pend = 470;
    w0 = n_writes;
    run_frame(40, -1, -1, -1, 0);
    chk_status("armvs");
    run_frame(480, 470, 479, 100, 5);
    vs_start();
    chk_status("trunc");
    chk("trunc_flag_const", int'(TRUNC), 1);
    chk("trunc_writes", n_writes - w0, 5760);
    chk("trunc_queue_empty", exp_q.size(), 0);

    // Phase 4: re-ARM from DONE clears flags; ENABLE dropped at write 1000.
    do_arm(0);
    chk_status("rearm");
    chk("rearm_done_cleared", int'({DONE, TRUNC}), 0);
    w0 = n_writes;
    drop_at = 1000;
    run_frame(4, 0, 1, -1, 0);
    drop_at = -1;
    chk_status("drop");
    chk("drop_writes", n_writes - w0, 1000);
    chk("drop_queue_empty", exp_q.size(), 0);
    ENABLE = 1'b1;
    w0 = n_writes;
    run_frame(4, 0, 1, -1, 0);
    chk("after_drop_writes", n_writes - w0, 0);

    // Phase 5: asynchronous reset mid-capture.
    do_arm(0);
    vs_start();
    for (int x = 0; x < 100; x++) cyc(1'b0, 1'b1, x, 0);
    #2;
    chk("prereset_we", int'(BRAM_WE), 1);
    RESET_N = 1'b0;
    #1;
    chk("async_reset_addr", int'(BRAM_ADDR), 0);
    chk("async_reset_din", int'(BRAM_DIN), 0);
    chk("async_reset_flags", int'({BRAM_WE, BUSY, DONE, TRUNC}), 0);
    exp_q.delete();
    m_wait  = 0;
    m_cap   = 0;
    m_done  = 0;
    m_trunc = 0;
    @(negedge O_CLK);
    @(negedge O_CLK);
    RESET_N = 1'b1;
    w0 = n_writes;
    for (int x = 0; x < 20; x++) cyc(1'b0, 1'b1, x, 0);
    chk_status("postreset");
    chk("postreset_writes", n_writes - w0, 0);

    repeat (4) @(negedge O_CLK);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
